// File: rtl/ooop_types.sv
// Shared types for the data-memory path.
// Contents: DMEM_ADDR_W (byte address width), DMEM_DATA_W (word width),
//           dmem_resp_t {valid, err, data} carried through the response pipe.
package ooop_types;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [DMEM_DATA_W-1:0] data;
  } dmem_resp_t;

endpackage

// File: rtl/dmem_lat_pipe.sv
// Purpose: RD_LAT-stage shift register of dmem_resp_t; kill_i clears every stage's
//          valid bit at the edge; valid bits reset asynchronously.
// Ports:   clk, rst_n, kill_i (sync flush), in_i (response entering stage 0),
//          out_o (last stage; err/data forced to 0 whenever valid is 0).
module dmem_lat_pipe
  import ooop_types::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kill_i,
  input  dmem_resp_t in_i,
  output dmem_resp_t out_o
);

  logic [RD_LAT-1:0]                  vld_q, vld_d;
  logic [RD_LAT-1:0]                  err_q, err_d;
  logic [RD_LAT-1:0][DMEM_DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d     = '0;
    err_d     = err_q;
    data_d    = data_q;
    vld_d[0]  = in_i.valid & ~kill_i;
    err_d[0]  = in_i.err;
    data_d[0] = in_i.data;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1] & ~kill_i;
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Only the valid bits need a reset; payload is masked at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    err_q  <= err_d;
    data_q <= data_d;
  end

  always_comb begin
    out_o       = '0;
    out_o.valid = vld_q[RD_LAT-1];
    if (vld_q[RD_LAT-1]) begin
      out_o.err  = err_q[RD_LAT-1];
      out_o.data = data_q[RD_LAT-1];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: memory side of the LSU dmem interface; word-addressed array returning
//          the full aligned word RD_LAT cycles after acceptance. Always ready.
// Ports:   clk, rst_n (async low), flush_i (kills in-flight + coincident request),
//          req_valid_i/req_addr_i/req_we_i/req_wdata_i/req_be_i (request),
//          rdata_o/rvalid_o/err_o (response; err_o = address out of range).
// Config:  DMEM_STORE_EN enables byte-enabled stores; otherwise every request is
//          a load and the array is read-only.
module dmem_responder
  import ooop_types::*;
#(
  parameter int XLEN_P      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  input  logic [DMEM_ADDR_W-1:0] req_addr_i,
  input  logic                   req_we_i,
  input  logic [XLEN_P-1:0]      req_wdata_i,
  input  logic [3:0]             req_be_i,
  output logic [XLEN_P-1:0]      rdata_o,
  output logic                   rvalid_o,
  output logic                   err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Contents are not reset; they start at zero.
  logic [XLEN_P-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic [IDX_W-1:0] idx;
  logic             oor;
  logic             accept;
  logic             is_store;
  dmem_resp_t       pipe_in;
  dmem_resp_t       pipe_out;

  assign idx    = req_addr_i[IDX_W+1:2];
  assign oor    = |req_addr_i[DMEM_ADDR_W-1:IDX_W+2];
  assign accept = req_valid_i & ~flush_i;

`ifdef DMEM_STORE_EN
  assign is_store = req_we_i;

  always_ff @(posedge clk) begin
    if (accept && is_store && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be_i[i]) mem_q[idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
      end
    end
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[1:0];
`else
  assign is_store = 1'b0;

  logic unused_store_inputs;
  assign unused_store_inputs = ^{req_we_i, req_wdata_i, req_be_i, req_addr_i[1:0]};
`endif

  // Read is sampled at the acceptance edge, so a store committed one edge
  // earlier is already in the array.
  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = accept;
    pipe_in.err   = oor;
    if (!oor && !is_store) pipe_in.data = mem_q[idx];
  end

  dmem_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill_i (flush_i),
    .in_i   (pipe_in),
    .out_o  (pipe_out)
  );

  assign rvalid_o = pipe_out.valid;
  assign err_o    = pipe_out.err;
  assign rdata_o  = pipe_out.data;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1024;

`ifdef DMEM_STORE_EN
  localparam logic [31:0] ST_RES = 32'h0022_3300;
  localparam bit          STORES = 1'b1;
`else
  localparam logic [31:0] ST_RES = 32'h0000_0000;
  localparam bit          STORES = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_be_i = '0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN_P(32), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        fl;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  vec_t        tbl[$];
  logic [31:0] mmem [DEPTH];
  rsp_t        sched [int];

  function automatic vec_t mk(logic v, logic [31:0] a, logic we, logic [31:0] wd,
                              logic [3:0] be, logic fl, logic ev, logic ee, logic [31:0] ed);
    vec_t r;
    r.v = v; r.a = a; r.we = we; r.wd = wd; r.be = be; r.fl = fl;
    r.ev = ev; r.ee = ee; r.ed = ed;
    return r;
  endfunction

  task automatic check(string name, logic ev, logic ee, logic [31:0] ed);
    n_cmp++;
    if (rvalid_o !== ev || err_o !== ee || rdata_o !== ed) begin
      n_bad++;
      $display("FAIL %s: got rvalid=%b err=%b rdata=%h, want rvalid=%b err=%b rdata=%h",
               name, rvalid_o, err_o, rdata_o, ev, ee, ed);
    end
  endtask

  task automatic drive(logic v, logic [31:0] a, logic we, logic [31:0] wd, logic [3:0] be, logic fl);
    req_valid_i = v; req_addr_i = a; req_we_i = we; req_wdata_i = wd; req_be_i = be; flush_i = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Preload image, mirrored into the reference model.
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    mmem[0] = 32'd1; mmem[1] = 32'd2; mmem[2] = 32'd3;
    mmem[4] = 32'hDEAD_BEEF; mmem[5] = 32'h5566_7788;
    dut.mem_q[0] = 32'd1; dut.mem_q[1] = 32'd2; dut.mem_q[2] = 32'd3;
    dut.mem_q[4] = 32'hDEAD_BEEF; dut.mem_q[5] = 32'h5566_7788;

    // Directed table: each row is driven before an edge and checked after it.
    // single load, latency 2, one-cycle strobe
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    // back-to-back loads
    tbl.push_back(mk(1, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h4,  0, 0, 0, 0,  1, 0, 32'd1));
    tbl.push_back(mk(1, 32'h8,  0, 0, 0, 0,  1, 0, 32'd2));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 0, 32'd3));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    // flush kills an in-flight load
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 1,  0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h14, 0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 0, 32'h5566_7788));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    // out-of-range load
    tbl.push_back(mk(1, 32'h0001_0000, 0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 1, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    // byte-enabled store then load (read-after-write on the next edge)
    tbl.push_back(mk(1, 32'h20, 1, 32'h1122_3344, 4'b0110, 0,  0, 0, 32'h0));
    tbl.push_back(mk(1, 32'h20, 0, 0, 0, 0,  1, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 0, ST_RES));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    // request coincident with flush is dropped
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 1,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    // low address bits ignored
    tbl.push_back(mk(1, 32'h13, 0, 0, 0, 0,  0, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 32'h0,  0, 0, 0, 0,  0, 0, 32'h0));
    mmem[8] = ST_RES;

    // Reset state
    #2;
    check("reset_state", 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].be, tbl[i].fl);
      @(negedge clk);
      check($sformatf("row%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].ed);
    end

    // Reset one cycle after a load: response lost, then normal operation.
    drive(1, 32'h10, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 check("rst_after_load", 0, 0, 32'h0);
    @(negedge clk);
    check("rst_held", 0, 0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_released", 0, 0, 32'h0);
    drive(1, 32'h4, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("post_rst_wait", 0, 0, 32'h0);
    @(negedge clk);
    check("post_rst_load", 1, 0, 32'd2);

    // Reset while a response is on the outputs: strobe drops asynchronously.
    drive(1, 32'h10, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("pre_async_rst", 1, 0, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1 check("async_rst_drop", 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Randomized traffic against a cycle-indexed reference model.
    begin
      int e_n;
      e_n = 0;
      for (int it = 0; it < 400; it++) begin
        logic        v, we, fl, oor;
        logic [31:0] a, wd, idx;
        logic [3:0]  be;
        rsp_t        r, exp_r;
        v  = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 9) == 0);
        we = ($urandom_range(0, 2) == 0);
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0)
          a = (32'($urandom_range(1, 65535)) << 16) | 32'($urandom_range(0, 4095));
        else if (we)
          a = (32'd16 + 32'($urandom_range(0, 15))) * 4;
        else
          a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
        drive(v, a, we, wd, be, fl);
        @(negedge clk);
        e_n++;
        oor = (a >= DEPTH * 4);
        idx = (a % (DEPTH * 4)) / 4;
        if (fl) begin
          for (int k = 0; k < RD_LAT; k++) sched.delete(e_n + k);
        end else if (v) begin
          r.v = 1'b1;
          r.e = oor;
          if (STORES && we) begin
            r.d = 32'h0;
            if (!oor)
              for (int b = 0; b < 4; b++)
                if (be[b]) mmem[idx][8*b +: 8] = wd[8*b +: 8];
          end else begin
            r.d = oor ? 32'h0 : mmem[idx];
          end
          sched[e_n + RD_LAT - 1] = r;
        end
        if (sched.exists(e_n)) begin
          exp_r = sched[e_n];
          sched.delete(e_n);
        end else begin
          exp_r.v = 1'b0; exp_r.e = 1'b0; exp_r.d = 32'h0;
        end
        check($sformatf("rand%0d", it), exp_r.v, exp_r.e, exp_r.d);
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
